// File: rtl/counter_req_arbiter_if.sv
// Request/grant bundle between the button-side requesters and the shared counter.
// The master side issues requests and clears; the slave side owns the counter state.
interface counter_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] dir;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic [N_REQ-1:0] gnt;
    logic             wrap_evt;
    logic             drop;

    modport master (
        output req, dir, clr,
        input  count, gnt, wrap_evt, drop
    );

    modport slave (
        input  req, dir, clr,
        output count, gnt, wrap_evt, drop
    );
endinterface

// File: rtl/counter_req_arbiter.sv
// Shared up/down counter fed by N_REQ one-deep request slots, serviced one per cycle
// by a round-robin arbiter; reports wrap/saturation events and lost requests.
module counter_req_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_req_arbiter_if.slave  bus_if
);
    localparam int PTR_W = $clog2(N_REQ);
    typedef logic [PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0] count_q, count_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic             wrap_q, wrap_d;
    logic             drop_q, drop_d;
    ptr_t             rr_ptr_q, rr_ptr_d;

    ptr_t             cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;
    logic             grant_any;
    ptr_t             grant_idx;
    logic [N_REQ-1:0] grant_vec;
    logic [WIDTH-1:0] step_val;
    logic             step_wrap;

    // Offset gi from the pointer maps to requester (rr_ptr + gi) mod N_REQ.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [PTR_W:0] sum;
        assign sum          = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (PTR_W+1)'(N_REQ)) ?
                              ptr_t'(sum - (PTR_W+1)'(N_REQ)) : sum[PTR_W-1:0];
        assign cand_hit[gi] = pend_q[cand_idx[gi]];
    end

    always_comb begin
        grant_any = |cand_hit;
        grant_idx = '0;
        // Walk from the far end so the smallest offset from the pointer wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_idx = cand_idx[i];
            end
        end
        grant_vec = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    end

    // Bounds are detected from the current value so WRAP=0 can hold instead of carrying.
    always_comb begin
        step_val  = count_q;
        step_wrap = 1'b0;
        if (grant_any) begin
            if (bus_if.dir[grant_idx]) begin
                if (&count_q) begin
                    step_wrap = 1'b1;
                    step_val  = WRAP ? '0 : count_q;
                end else begin
                    step_val  = count_q + WIDTH'(1);
                end
            end else begin
                if (~|count_q) begin
                    step_wrap = 1'b1;
                    step_val  = WRAP ? '1 : count_q;
                end else begin
                    step_val  = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        count_d  = step_val;
        wrap_d   = step_wrap;
        gnt_d    = grant_vec;
        pend_d   = (pend_q & ~grant_vec) | bus_if.req;
        drop_d   = drop_q | (|(bus_if.req & pend_q & ~grant_vec));
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == ptr_t'(N_REQ - 1)) ? '0 : grant_idx + ptr_t'(1);
        end
        // Clear wipes everything except the fairness pointer and cancels this edge's grant.
        if (bus_if.clr) begin
            count_d  = '0;
            wrap_d   = 1'b0;
            gnt_d    = '0;
            pend_d   = '0;
            drop_d   = 1'b0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            gnt_q    <= '0;
            pend_q   <= '0;
            wrap_q   <= 1'b0;
            drop_q   <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            gnt_q    <= gnt_d;
            pend_q   <= pend_d;
            wrap_q   <= wrap_d;
            drop_q   <= drop_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus_if.count    = count_q;
    assign bus_if.gnt      = gnt_q;
    assign bus_if.wrap_evt = wrap_q;
    assign bus_if.drop     = drop_q;
endmodule

// File: tb/tb_counter_req_arbiter.sv
// Bench for counter_req_arbiter: a wrapping and a saturating instance share one stimulus
// stream; directed scenarios check fixed values, a random run checks against a model.
module tb_counter_req_arbiter;
    localparam int N    = 4;
    localparam int W    = 4;
    localparam int MAXV = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    counter_req_arbiter_if #(.N_REQ(N), .WIDTH(W)) if_w ();
    counter_req_arbiter_if #(.N_REQ(N), .WIDTH(W)) if_s ();

    counter_req_arbiter #(.N_REQ(N), .WIDTH(W), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .bus_if(if_w)
    );
    counter_req_arbiter #(.N_REQ(N), .WIDTH(W), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .bus_if(if_s)
    );

    int total = 0;
    int bad   = 0;

    // Reference model, index 0 = wrapping instance, 1 = saturating instance.
    int       m_count [2];
    bit [3:0] m_pend  [2];
    int       m_ptr   [2];
    bit       m_drop  [2];
    bit       m_wrap  [2];
    bit [3:0] m_gnt   [2];

    task automatic model_edge(input int u, input bit wrapm, input logic [3:0] r,
                              input logic [3:0] d, input bit c, input bit x);
        int k;
        bit [3:0] old;
        if (x) begin
            m_count[u] = 0; m_pend[u] = 0; m_ptr[u] = 0;
            m_drop[u] = 0; m_wrap[u] = 0; m_gnt[u] = 0;
        end else if (c) begin
            m_count[u] = 0; m_pend[u] = 0;
            m_drop[u] = 0; m_wrap[u] = 0; m_gnt[u] = 0;
        end else begin
            k = -1;
            for (int off = 0; off < N; off++) begin
                if (k < 0 && m_pend[u][(m_ptr[u] + off) % N]) k = (m_ptr[u] + off) % N;
            end
            old = m_pend[u];
            m_wrap[u] = 0;
            m_gnt[u]  = 0;
            if (k >= 0) begin
                if (d[k]) begin
                    if (m_count[u] == MAXV) begin
                        m_wrap[u] = 1;
                        m_count[u] = wrapm ? 0 : MAXV;
                    end else m_count[u] = m_count[u] + 1;
                end else begin
                    if (m_count[u] == 0) begin
                        m_wrap[u] = 1;
                        m_count[u] = wrapm ? MAXV : 0;
                    end else m_count[u] = m_count[u] - 1;
                end
                m_gnt[u] = 4'(1 << k);
                m_ptr[u] = (k + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (r[i] && old[i] && i != k) m_drop[u] = 1;
                m_pend[u][i] = r[i] | (old[i] && i != k);
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d, input bit c, input bit x);
        if_w.req = r; if_w.dir = d; if_w.clr = c;
        if_s.req = r; if_s.dir = d; if_s.clr = c;
        rst = x;
        @(posedge clk);
        model_edge(0, 1'b1, r, d, c, x);
        model_edge(1, 1'b0, r, d, c, x);
        #1;
        $display("t=%0t req=%b dir=%b clr=%0b rst=%0b | W cnt=%0d gnt=%b wr=%0b dr=%0b | S cnt=%0d gnt=%b wr=%0b dr=%0b",
                 $time, r, d, c, x, if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop,
                 if_s.count, if_s.gnt, if_s.wrap_evt, if_s.drop);
    endtask

    task automatic burst(input logic [3:0] r, input logic [3:0] d);
        step(r, d, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, d, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        total++;
        if ({if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop} !== 10'd0) begin
            bad++; $display("FAIL reset_w: got %b want 0", {if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop});
        end
        total++;
        if ({if_s.count, if_s.gnt, if_s.wrap_evt, if_s.drop} !== 10'd0) begin
            bad++; $display("FAIL reset_s: got %b want 0", {if_s.count, if_s.gnt, if_s.wrap_evt, if_s.drop});
        end
    endtask

    task automatic test_single();
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        step(4'b0001, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.count !== 4'd0 || if_w.gnt !== 4'b0000) begin
            bad++; $display("FAIL single_latency: got cnt=%0d gnt=%b want cnt=0 gnt=0000", if_w.count, if_w.gnt);
        end
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.count !== 4'd1 || if_w.gnt !== 4'b0001 || if_w.drop !== 1'b0) begin
            bad++; $display("FAIL single_grant: got cnt=%0d gnt=%b drop=%b want 1 0001 0", if_w.count, if_w.gnt, if_w.drop);
        end
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.gnt !== 4'b0000 || if_w.count !== 4'd1) begin
            bad++; $display("FAIL single_pulse: got cnt=%0d gnt=%b want 1 0000", if_w.count, if_w.gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        step(4'b0000, 4'b0101, 1'b0, 1'b1);
        step(4'b1111, 4'b0101, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 4'b0101, 1'b0, 1'b0);
            exp_g = 4'(1 << i);
            total++;
            if (if_w.gnt !== exp_g || if_w.count !== 4'((i + 1) % 2)) begin
                bad++; $display("FAIL rr_seq%0d: got gnt=%b cnt=%0d want gnt=%b cnt=%0d",
                                i, if_w.gnt, if_w.count, exp_g, (i + 1) % 2);
            end
        end
        total++;
        if (if_w.drop !== 1'b0) begin
            bad++; $display("FAIL rr_drop: got %b want 0", if_w.drop);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [3];
        exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b0100;
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        step(4'b0100, 4'b1111, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.gnt !== 4'b0100) begin
            bad++; $display("FAIL rot_first: got %b want 0100", if_w.gnt);
        end
        step(4'b1101, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b1111, 1'b0, 1'b0);
            total++;
            if (if_w.gnt !== exp_g[i]) begin
                bad++; $display("FAIL rot_seq%0d: got %b want %b", i, if_w.gnt, exp_g[i]);
            end
        end
    endtask

    task automatic test_drop();
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        step(4'b0011, 4'b1111, 1'b0, 1'b0);
        step(4'b0010, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.drop !== 1'b1 || if_w.gnt !== 4'b0001) begin
            bad++; $display("FAIL drop_set: got drop=%b gnt=%b want 1 0001", if_w.drop, if_w.gnt);
        end
        step(4'b0010, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.count !== 4'd3 || if_w.drop !== 1'b1) begin
            bad++; $display("FAIL drop_sticky: got cnt=%0d drop=%b want 3 1", if_w.count, if_w.drop);
        end
        step(4'b0000, 4'b1111, 1'b1, 1'b0);
        total++;
        if (if_w.drop !== 1'b0) begin
            bad++; $display("FAIL drop_clr: got %b want 0", if_w.drop);
        end
    endtask

    task automatic test_bounds();
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        burst(4'b1111, 4'b1111);
        burst(4'b1111, 4'b1111);
        burst(4'b1111, 4'b1111);
        burst(4'b0111, 4'b1111);
        total++;
        if (if_w.count !== 4'd15 || if_s.count !== 4'd15 || if_w.wrap_evt !== 1'b0) begin
            bad++; $display("FAIL bound_fill: got w=%0d s=%0d wr=%b want 15 15 0", if_w.count, if_s.count, if_w.wrap_evt);
        end
        step(4'b0001, 4'b1111, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.count !== 4'd0 || if_w.wrap_evt !== 1'b1) begin
            bad++; $display("FAIL wrap_up: got cnt=%0d wr=%b want 0 1", if_w.count, if_w.wrap_evt);
        end
        total++;
        if (if_s.count !== 4'd15 || if_s.wrap_evt !== 1'b1) begin
            bad++; $display("FAIL sat_up: got cnt=%0d wr=%b want 15 1", if_s.count, if_s.wrap_evt);
        end
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.wrap_evt !== 1'b0 || if_s.wrap_evt !== 1'b0) begin
            bad++; $display("FAIL wrap_pulse: got w=%b s=%b want 0 0", if_w.wrap_evt, if_s.wrap_evt);
        end
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        total++;
        if (if_w.count !== 4'd15 || if_w.wrap_evt !== 1'b1 || if_s.count !== 4'd14 || if_s.wrap_evt !== 1'b0) begin
            bad++; $display("FAIL wrap_down: got w=%0d/%b s=%0d/%b want 15/1 14/0",
                            if_w.count, if_w.wrap_evt, if_s.count, if_s.wrap_evt);
        end
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        total++;
        if (if_s.count !== 4'd0 || if_s.wrap_evt !== 1'b1 || if_w.count !== 4'd15) begin
            bad++; $display("FAIL sat_down: got s=%0d/%b w=%0d want 0/1 15", if_s.count, if_s.wrap_evt, if_w.count);
        end
    endtask

    task automatic test_clear();
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        burst(4'b1111, 4'b1111);
        burst(4'b1111, 4'b1111);
        burst(4'b0001, 4'b1111);
        step(4'b0110, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.count !== 4'd9) begin
            bad++; $display("FAIL clr_setup: got %0d want 9", if_w.count);
        end
        step(4'b0001, 4'b1111, 1'b1, 1'b0);
        total++;
        if ({if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop} !== 10'd0) begin
            bad++; $display("FAIL clr_now: got %b want 0", {if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop});
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b1111, 1'b0, 1'b0);
            total++;
            if (if_w.gnt !== 4'b0000 || if_w.count !== 4'd0) begin
                bad++; $display("FAIL clr_idle%0d: got gnt=%b cnt=%0d want 0000 0", i, if_w.gnt, if_w.count);
            end
        end
        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.gnt !== 4'b0010) begin
            bad++; $display("FAIL clr_keeps_ptr: got %b want 0010", if_w.gnt);
        end
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b1111, 1'b0, 1'b0);
        step(4'b0110, 4'b1111, 1'b0, 1'b0);
        step(4'b0001, 4'b1111, 1'b1, 1'b1);
        total++;
        if ({if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop} !== 10'd0) begin
            bad++; $display("FAIL rst_clr: got %b want 0", {if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop});
        end
        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        total++;
        if (if_w.gnt !== 4'b0001) begin
            bad++; $display("FAIL rst_ptr: got %b want 0001", if_w.gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r, d;
        bit c, x;
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            r = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 39) == 0);
            x = ($urandom_range(0, 99) == 0);
            step(r, d, c, x);
            total++;
            if ({if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop} !==
                {4'(m_count[0]), m_gnt[0], m_wrap[0], m_drop[0]}) begin
                bad++; $display("FAIL rand_w%0d: got cnt=%0d gnt=%b wr=%b dr=%b want cnt=%0d gnt=%b wr=%b dr=%b", n,
                                if_w.count, if_w.gnt, if_w.wrap_evt, if_w.drop, m_count[0], m_gnt[0], m_wrap[0], m_drop[0]);
            end
            total++;
            if ({if_s.count, if_s.gnt, if_s.wrap_evt, if_s.drop} !==
                {4'(m_count[1]), m_gnt[1], m_wrap[1], m_drop[1]}) begin
                bad++; $display("FAIL rand_s%0d: got cnt=%0d gnt=%b wr=%b dr=%b want cnt=%0d gnt=%b wr=%b dr=%b", n,
                                if_s.count, if_s.gnt, if_s.wrap_evt, if_s.drop, m_count[1], m_gnt[1], m_wrap[1], m_drop[1]);
            end
        end
    endtask

    initial begin
        if_w.req = '0; if_w.dir = '0; if_w.clr = 1'b0;
        if_s.req = '0; if_s.dir = '0; if_s.clr = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_count[u] = 0; m_pend[u] = 0; m_ptr[u] = 0;
            m_drop[u] = 0; m_wrap[u] = 0; m_gnt[u] = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_rotation();
        test_drop();
        test_bounds();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
